// File: rtl/cbus_mem_responder_pkg.sv
// cbus_mem_responder_pkg
// Shared CBus request/response types, responder FSM states and small
// data helpers used by the bus-level memory model.
package cbus_mem_responder_pkg;

  typedef logic [3:0] cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2,
    DONE = 2'd3
  } cbus_mem_state_t;

  // Seed the stall LFSR returns to on every reset.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Replace the byte lanes of old_word selected by strobe with new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strobe);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strobe[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

  // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

endpackage

// File: rtl/cbus_mem_responder_array.sv
// cbus_mem_array
// Byte-strobed single-port word RAM with asynchronous read. Storage is
// never cleared by reset. Words are held XOR-ed with INIT_WORD so that
// storage that powers up as zero reads back as INIT_WORD until written.
module cbus_mem_array
  import cbus_mem_responder_pkg::*;
#(
  parameter int          WORDS     = 4096,
  parameter int          IDX_W     = 12,
  parameter logic [31:0] INIT_WORD = 32'h0
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_r [WORDS];

  assign rdata = mem_r[idx] ^ INIT_WORD;

  // Merge the strobed byte lanes of wdata into the addressed word.
  always_ff @(posedge clk) begin
    if (we != 4'b0000) begin
      mem_r[idx] <= byte_merge(rdata, wdata, we) ^ INIT_WORD;
    end
  end

endmodule

// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder
// CBus responder backed by an internal word RAM. Serves single and INCR
// burst reads/writes with a programmable first-beat latency.
// Optional build macro: CBUS_MEM_RANDOM_STALL_EN inserts pseudo-random
// single-cycle gaps between beats (16-bit LFSR, seed 16'hACE1).
// All responses and busy come straight from flops; the RAM is read one
// cycle ahead so read data lands in the same cycle as ready.
module cbus_mem_responder
  import cbus_mem_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] INIT_WORD = 32'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       busy
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  cbus_mem_state_t  state_r, state_nxt_s;
  logic [3:0]       wait_cnt_r, wait_cnt_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  cbus_len_t        len_r, len_nxt_s;
  cbus_len_t        beat_r, beat_nxt_s;
  logic             is_write_r, is_write_nxt_s;

  logic             ready_r, ready_nxt_s;
  logic             last_r, last_nxt_s;
  logic [31:0]      data_r, data_nxt_s;
  logic             busy_r, busy_nxt_s;

  logic             stall_nxt_s;
  logic             wr_en_s;
  logic [3:0]       ram_we_s;
  logic [IDX_W-1:0] ram_idx_s;
  logic [31:0]      ram_rdata_s;

  // Fields that carry no meaning for a word-addressed memory.
  logic unused_s;
  assign unused_s = ^{creq.size, creq.addr[31:IDX_W+2], creq.addr[1:0]};

`ifdef CBUS_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_r;
  logic [15:0] lfsr_nxt_s;

  assign lfsr_nxt_s  = lfsr_step(lfsr_r);
  // A beat is withheld in any BEAT cycle whose LFSR low bits are zero.
  assign stall_nxt_s = (lfsr_nxt_s[1:0] == 2'b00);

  // Free-running stall LFSR, stepped every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_nxt_s;
    end
  end
`else
  assign stall_nxt_s = 1'b0;
`endif

  // During a write beat the port writes the current word; otherwise it
  // prefetches the word the next cycle will present.
  assign wr_en_s   = (state_r == BEAT) && ready_r && is_write_r;
  assign ram_we_s  = wr_en_s ? creq.strobe : 4'b0000;
  assign ram_idx_s = wr_en_s ? idx_r : idx_nxt_s;

  cbus_mem_array #(
    .WORDS     (MEM_WORDS),
    .IDX_W     (IDX_W),
    .INIT_WORD (INIT_WORD)
  ) u_array (
    .clk   (clk),
    .we    (ram_we_s),
    .idx   (ram_idx_s),
    .wdata (creq.data),
    .rdata (ram_rdata_s)
  );

  // Next-state and transaction bookkeeping for the protocol FSM.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    idx_nxt_s      = idx_r;
    len_nxt_s      = len_r;
    beat_nxt_s     = beat_r;
    is_write_nxt_s = is_write_r;
    case (state_r)
      IDLE: begin
        if (creq.valid) begin
          is_write_nxt_s = creq.is_write;
          idx_nxt_s      = creq.addr[IDX_W+1:2];
          len_nxt_s      = creq.len;
          beat_nxt_s     = 4'd0;
          wait_cnt_nxt_s = 4'(LATENCY - 1);
          state_nxt_s    = (LATENCY == 1) ? BEAT : WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        // Leaving when the counter would hit zero puts the first beat
        // exactly LATENCY cycles after acceptance.
        if (wait_cnt_r <= 4'd1) begin
          wait_cnt_nxt_s = 4'd0;
          state_nxt_s    = BEAT;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r - 4'd1;
        end
      end
      BEAT: begin
        if (ready_r) begin
          idx_nxt_s = idx_r + IDX_W'(1);
          if (beat_r == len_r) begin
            beat_nxt_s  = 4'd0;
            state_nxt_s = DONE;
          end else begin
            beat_nxt_s = beat_r + 4'd1;
          end
        end else begin
          state_nxt_s = BEAT;
        end
      end
      DONE: begin
        // A valid still held from the finished request must not restart.
        if (!creq.valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Response values for the coming cycle, registered below.
  always_comb begin
    ready_nxt_s = (state_nxt_s == BEAT) && !stall_nxt_s;
    last_nxt_s  = ready_nxt_s && (beat_nxt_s == len_nxt_s);
    busy_nxt_s  = (state_nxt_s != IDLE);
    if (ready_nxt_s && !is_write_nxt_s) begin
      data_nxt_s = ram_rdata_s;
    end else begin
      data_nxt_s = 32'h0;
    end
  end

  // State, bookkeeping and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      wait_cnt_r <= 4'd0;
      idx_r      <= '0;
      len_r      <= 4'd0;
      beat_r     <= 4'd0;
      is_write_r <= 1'b0;
      ready_r    <= 1'b0;
      last_r     <= 1'b0;
      data_r     <= 32'h0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      idx_r      <= idx_nxt_s;
      len_r      <= len_nxt_s;
      beat_r     <= beat_nxt_s;
      is_write_r <= is_write_nxt_s;
      ready_r    <= ready_nxt_s;
      last_r     <= last_nxt_s;
      data_r     <= data_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign cresp.ready = ready_r;
  assign cresp.last  = last_r;
  assign cresp.data  = data_r;
  assign busy        = busy_r;

endmodule
